// File: rtl/ahb_gpio_ctrl.sv
// AHB-Lite GPIO controller: output/direction registers, synchronized pin readback,
// rising-edge interrupt status with enable mask, and atomic SET/CLR views of OUT.
module ahb_gpio_ctrl #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] pin_dir,
  output logic [31:0] pin_out,
  input  logic [31:0] pin_in,
  output logic        irq
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 3;

  localparam logic [AW-1:0] A_OUT = 3'd0;
  localparam logic [AW-1:0] A_DIR = 3'd1;
  localparam logic [AW-1:0] A_IN  = 3'd2;
  localparam logic [AW-1:0] A_IE  = 3'd3;
  localparam logic [AW-1:0] A_IS  = 3'd4;
  localparam logic [AW-1:0] A_SET = 3'd5;
  localparam logic [AW-1:0] A_CLR = 3'd6;

  logic [DW-1:0] out_q, dir_q, ie_q, is_q, prev_q;
  logic [DW-1:0] out_n, dir_n, ie_n, is_n;
  logic [DW-1:0] sync_q [SYNC_STAGES];
  logic          dp_valid_q, dp_write_q;
  logic [AW-1:0] dp_addr_q;
  logic [DW-1:0] in_c, rise_c, rdata_c;
  logic          accept_c, wr_en_c;
  logic          unused_bits;

  assign unused_bits = ^{HADDR[31:5], HADDR[1:0], HTRANS[0]};

  assign accept_c = HSEL & HREADY & HTRANS[1];
  assign wr_en_c  = dp_valid_q & dp_write_q;
  assign in_c     = sync_q[SYNC_STAGES-1];
  assign rise_c   = in_c & ~prev_q;

  // Address-phase capture; an unaccepted cycle leaves an idle data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_addr_q  <= '0;
    end else if (accept_c) begin
      dp_valid_q <= 1'b1;
      dp_write_q <= HWRITE;
      dp_addr_q  <= HADDR[4:2];
    end else begin
      dp_valid_q <= 1'b0;
    end
  end

  // Pad synchronizer plus one extra stage for edge detection.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= pin_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= in_c;
    end
  end

  // Register write decode; a rising edge overrides a same-cycle W1C.
  always_comb begin
    out_n = out_q;
    dir_n = dir_q;
    ie_n  = ie_q;
    is_n  = is_q;
    if (wr_en_c) begin
      case (dp_addr_q)
        A_OUT:   out_n = HWDATA;
        A_DIR:   dir_n = HWDATA;
        A_IE:    ie_n  = HWDATA;
        A_IS:    is_n  = is_q & ~HWDATA;
        A_SET:   out_n = out_q | HWDATA;
        A_CLR:   out_n = out_q & ~HWDATA;
        default: ;
      endcase
    end
    is_n = is_n | rise_c;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      out_q <= '0;
      dir_q <= '0;
      ie_q  <= '0;
      is_q  <= '0;
    end else begin
      out_q <= out_n;
      dir_q <= dir_n;
      ie_q  <= ie_n;
      is_q  <= is_n;
    end
  end

  // Read mux; write-only, unmapped and idle data phases read as zero.
  always_comb begin
    rdata_c = '0;
    if (dp_valid_q && !dp_write_q) begin
      case (dp_addr_q)
        A_OUT:   rdata_c = out_q;
        A_DIR:   rdata_c = dir_q;
        A_IN:    rdata_c = in_c;
        A_IE:    rdata_c = ie_q;
        A_IS:    rdata_c = is_q;
        default: rdata_c = '0;
      endcase
    end
  end

  assign HRDATA    = rdata_c;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign pin_out   = out_q;
  assign pin_dir   = dir_q;
  assign irq       = |(is_q & ie_q);

endmodule

// File: tb/tb_ahb_gpio_ctrl.sv
// Bench for ahb_gpio_ctrl: directed AHB transfers; read expectations queued at issue
// and compared by an independent data-phase monitor, pin/irq levels checked inline.
module tb_ahb_gpio_ctrl;

  localparam logic [31:0] R_OUT = 32'h00, R_DIR = 32'h04, R_IN  = 32'h08, R_IE = 32'h0C;
  localparam logic [31:0] R_IS  = 32'h10, R_SET = 32'h14, R_CLR = 32'h18, R_UNM = 32'h1C;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] pin_dir;
  logic [31:0] pin_out;
  logic [31:0] pin_in;
  logic        irq;

  ahb_gpio_ctrl #(.SYNC_STAGES(2)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .pin_dir(pin_dir), .pin_out(pin_out),
    .pin_in(pin_in), .irq(irq)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic rd_dp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Bench-side view of which cycles are read data phases.
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) rd_dp <= 1'b0;
    else          rd_dp <= HSEL & HREADY & HTRANS[1] & ~HWRITE;
  end

  always @(negedge HCLK) begin
    if (rd_dp) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_read actual=0x%08h expected=none", HRDATA);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, HRDATA, e.data);
      end
    end
  end

  task automatic bus_cycle(input logic sel, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata);
    HSEL   = sel;
    HTRANS = sel ? 2'b10 : 2'b00;
    HWRITE = wr;
    HADDR  = addr;
    HWDATA = wdata;
    @(posedge HCLK);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus_cycle(1'b1, 1'b1, addr, 32'h0);
    bus_cycle(1'b0, 1'b0, 32'h0, data);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    exp_t e;
    e.data = exp;
    e.name = name;
    exp_q.push_back(e);
    bus_cycle(1'b1, 1'b0, addr, 32'h0);
    bus_cycle(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus_cycle(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    HRESETn = 1'b0;
    HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0; HREADY = 1'b1; HWDATA = '0;
    pin_in = '0;
    repeat (2) @(posedge HCLK);
    #1;
    check("rst_pin_dir", pin_dir, 32'h0);
    check("rst_pin_out", pin_out, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_hrdata", HRDATA, 32'h0);
    check("hreadyout", 32'(HREADYOUT), 32'h1);
    check("hresp", 32'(HRESP), 32'h0);
    HRESETn = 1'b1;
    idle(2);

    // Basic DIR/OUT programming reflected on the pins.
    wr(R_DIR, 32'h0000_00FF);
    check("pin_dir_after_wr", pin_dir, 32'h0000_00FF);
    wr(R_OUT, 32'hA5A5_A5A5);
    check("pin_out_after_wr", pin_out, 32'hA5A5_A5A5);
    rd(R_DIR, 32'h0000_00FF, "rd_dir");
    rd(R_OUT, 32'hA5A5_A5A5, "rd_out");

    // Write followed immediately by a read of the same register.
    bus_cycle(1'b1, 1'b1, R_IE, 32'h0);
    e.data = 32'h1234_5678; e.name = "rd_ie_b2b";
    exp_q.push_back(e);
    bus_cycle(1'b1, 1'b0, R_IE, 32'h1234_5678);
    bus_cycle(1'b0, 1'b0, 32'h0, 32'h0);
    check("irq_no_status", 32'(irq), 32'h0);

    // SET/CLR views and ignored writes.
    wr(R_OUT, 32'h0000_000F);
    wr(R_SET, 32'h0000_00F0);
    rd(R_OUT, 32'h0000_00FF, "rd_out_after_set");
    check("pin_out_after_set", pin_out, 32'h0000_00FF);
    wr(R_CLR, 32'h0000_0003);
    rd(R_OUT, 32'h0000_00FC, "rd_out_after_clr");
    wr(R_IN, 32'hFFFF_FFFF);
    wr(R_UNM, 32'hFFFF_FFFF);
    HSEL = 1'b1; HWRITE = 1'b1; HADDR = R_OUT; HTRANS = 2'b00;
    @(posedge HCLK); #1;
    bus_cycle(1'b0, 1'b0, 32'h0, 32'h0);
    check("pin_out_idle_trans", pin_out, 32'h0000_00FC);
    rd(R_OUT, 32'h0000_00FC, "rd_out_after_in_wr");
    rd(R_DIR, 32'h0000_00FF, "rd_dir_after_in_wr");
    rd(R_IE, 32'h1234_5678, "rd_ie_after_in_wr");
    rd(R_IS, 32'h0, "rd_is_quiet");
    rd(R_IN, 32'h0, "rd_in_quiet");
    rd(R_SET, 32'h0, "rd_set_wo");
    rd(R_UNM, 32'h0, "rd_unmapped");
    wr(R_IE, 32'h0000_0008);

    // Rising edge on pin 3 through the synchronizer into IS and irq.
    pin_in = 32'h0000_0008;
    idle(1);
    check("irq_before_sync", 32'(irq), 32'h0);
    rd(R_IN, 32'h0000_0008, "rd_in_bit3");
    check("irq_after_edge", 32'(irq), 32'h1);
    rd(R_IS, 32'h0000_0008, "rd_is_bit3");
    wr(R_IS, 32'h0000_0008);
    check("irq_after_w1c", 32'(irq), 32'h0);
    rd(R_IS, 32'h0, "rd_is_cleared");

    // Rise on bit 0 landing on the same edge as a W1C of bit 0.
    pin_in = 32'h0000_0009;
    idle(1);
    bus_cycle(1'b1, 1'b1, R_IS, 32'h0);
    bus_cycle(1'b0, 1'b0, 32'h0, 32'h0000_0001);
    rd(R_IS, 32'h0000_0001, "rd_is_set_wins");
    check("irq_masked_bit0", 32'(irq), 32'h0);
    wr(R_IS, 32'h0000_0001);
    rd(R_IS, 32'h0, "rd_is_bit0_cleared");

    // Raise irq, then reset in the middle of a write data phase.
    pin_in = 32'h0;
    idle(4);
    pin_in = 32'h0000_0008;
    idle(4);
    check("irq_before_reset", 32'(irq), 32'h1);
    pin_in = 32'h0;
    idle(4);
    bus_cycle(1'b1, 1'b1, R_OUT, 32'h0);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0;
    HWDATA = 32'hFFFF_FFFF;
    #2 HRESETn = 1'b0;
    #1;
    check("async_rst_pin_out", pin_out, 32'h0);
    check("async_rst_pin_dir", pin_dir, 32'h0);
    check("async_rst_irq", 32'(irq), 32'h0);
    check("async_rst_hrdata", HRDATA, 32'h0);
    @(posedge HCLK); #1;
    check("rst_held_pin_out", pin_out, 32'h0);
    #3 HRESETn = 1'b1;
    @(posedge HCLK); #1;
    HWDATA = 32'h0;
    idle(3);
    check("post_rst_pin_out", pin_out, 32'h0);
    check("post_rst_irq", 32'(irq), 32'h0);
    rd(R_OUT, 32'h0, "rd_out_post_rst");
    rd(R_DIR, 32'h0, "rd_dir_post_rst");
    rd(R_IE, 32'h0, "rd_ie_post_rst");
    rd(R_IS, 32'h0, "rd_is_post_rst");

    idle(2);
    check("scoreboard_drain", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
